// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream and writes it into instruction memory.
// The frame is a 16-bit little-endian word count L, followed by 4*L data bytes. The bytes of
// each word arrive little-endian. The CPU is held in stall until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, the frame ends with one more
// byte, the XOR of all preceding frame bytes.
module imem_loader #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // The word counter must never wrap. The packing logic assumes 4-byte words.
  if (MAX_WORDS < 1 || MAX_WORDS > 65535 || (64'(MAX_WORDS) >= (64'd1 << ADDR_W)) || DATA_W != 32)
  begin : g_bad_cfg
    $error("imem_loader: illegal MAX_WORDS/ADDR_W/DATA_W combination");
  end

  localparam logic [16:0] MAX_L = 17'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR
  } state_t;
`endif

  state_t state, state_nxt;

  logic              accept;
  logic              rearm;
  logic [7:0]        len_lo;
  logic [15:0]       len_full;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] word_cnt;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept   = in_valid & in_ready;
  assign rearm    = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign len_full = {in_data, len_lo};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_hold  = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (accept) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (accept) begin
          if ({1'b0, len_full} > MAX_L) state_nxt = S_ERR;
`ifdef LOADER_CHECKSUM_EN
          else if (len_full == 16'd0)    state_nxt = S_CSUM;
`else
          else if (len_full == 16'd0)    state_nxt = S_DONE;
`endif
          else                           state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (accept && byte_idx == 2'd3 && word_cnt == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = S_LEN_LO;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nxt = S_LEN_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte packing, word counting and the registered memory write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_lo     <= '0;
      last_idx   <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (rearm) begin
        word_cnt <= '0;
        byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        if (state != S_CSUM) csum <= csum ^ in_data;
`endif
        unique case (state)
          S_LEN_LO: len_lo <= in_data;
          S_LEN_HI: begin
            // The stored value is L-1, so the last-word test is a plain equality.
            // A value of L=0 never reaches DATA, so the wrap of L-1 is harmless.
            last_idx <= ADDR_W'(len_full - 16'd1);
            byte_idx <= '0;
          end
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt;
                imem_wdata <= {in_data, word_buf};
                word_cnt   <= word_cnt + ADDR_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: a directed and randomized bench for imem_loader.
// The reference model is a list of the words that each frame carries. Every frame must
// produce exactly that list of writes, at addresses 0..L-1, and then the status that the
// frame rules require.
module tb_imem_loader;
  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.ADDR_W(16), .DATA_W(32), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit gaps = 1'b0;
  logic [15:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] words[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_hold"}, 64'(cpu_hold), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // Sends one complete frame carrying the words in the queue, then compares the writes and the status.
  task automatic run_frame(input bit bad_csum, input bit mid_start);
    int          len;
    logic [15:0] len16;
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    bit          ok;
    len   = words.size();
    len16 = 16'(len);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    cs = len16[7:0] ^ len16[15:8];
    send_byte(len16[7:0]);
    send_byte(len16[15:8]);
    for (int i = 0; i < len; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        b  = w[8*k +: 8];
        cs = cs ^ b;
        send_byte(b);
        if (mid_start && i == 0 && k == 1) pulse_start();
      end
    end
    ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? ~cs : cs);
    ok = !bad_csum;
`else
    if (len > 0) chk("last_we", 64'(imem_we), 64'd1);
`endif
    chk("done", 64'(done), 64'(ok));
    chk("err", 64'(err), 64'(!ok));
    chk("cpu_hold", 64'(cpu_hold), 64'(!ok));
    repeat (3) tick();
    chk("in_ready_idle", 64'(in_ready), 64'd0);
    chk("wr_count", 64'(wr_addr_q.size()), 64'(len));
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      chk("wr_addr", 64'(wr_addr_q[i]), 64'(i));
      chk("wr_data", 64'(wr_data_q[i]), 64'(words[i]));
    end
  endtask

  task automatic random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Bytes offered while IDLE are ignored
    wr_addr_q.delete();
    in_valid = 1'b1;
    repeat (3) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("idle_ready", 64'(in_ready), 64'd0);
    chk("idle_writes", 64'(wr_addr_q.size()), 64'd0);

    // Directed two-word program
    words.delete();
    words.push_back(32'h0050_0013);
    words.push_back(32'h00A0_0093);
    run_frame(1'b0, 1'b0);

    // Bytes offered while DONE are ignored
    wr_addr_q.delete();
    in_valid = 1'b1;
    repeat (4) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("done_writes", 64'(wr_addr_q.size()), 64'd0);
    chk("done_hold", 64'(done), 64'd1);

`ifdef LOADER_CHECKSUM_EN
    // Directed two-word program with a corrupted checksum
    run_frame(1'b1, 1'b0);
`endif

    // Empty program
    words.delete();
    run_frame(1'b0, 1'b0);

    // Oversized length is rejected with no writes
    wr_addr_q.delete();
    pulse_start();
    send_byte(8'(MAXW + 1));
    send_byte(8'h00);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_done", 64'(done), 64'd0);
    chk("ovf_ready", 64'(in_ready), 64'd0);
    chk("ovf_hold", 64'(cpu_hold), 64'd1);
    repeat (3) tick();
    chk("ovf_writes", 64'(wr_addr_q.size()), 64'd0);

    // Restart from ERR with a one-word frame, then the largest legal program
    random_words(1);
    run_frame(1'b0, 1'b0);
    random_words(MAXW);
    run_frame(1'b0, 1'b0);

    // Reset in the middle of word 1 aborts the load
    gaps = 1'b1;
    pulse_start();
    send_byte(8'd3);
    send_byte(8'd0);
    for (int k = 0; k < 6; k++) send_byte(8'($urandom));
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    tick();
    random_words(3);
    run_frame(1'b0, 1'b0);

    // Randomized frames: random lengths, random valid gaps, start pulses ignored mid-load
    for (int f = 0; f < 8; f++) begin
      gaps = $urandom_range(0, 1) == 1;
      random_words($urandom_range(1, MAXW));
      run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
